pll_lock_reset_ctrl: RTL
========================

# pll_lock_reset_ctrl

PLL sequencing and fabric reset controller that sits directly around the fabric CCC/PLL wrapper. It drives the PLL's active-low powerdown input and consumes the PLL lock output. It filters lock, retries the PLL on lock timeout, and releases a synchronous fabric reset only after lock is stable and device initialisation is done. It runs from a free-running clock that is not derived from the PLL, so it keeps operating while the PLL is powered down.

## Interface

Parameters:
- PD_CYCLES, 16: cycles PLL_POWERDOWN_N is held low per powerdown episode (≥2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a PLL retry (≥2).
- LOCK_FILTER, 256: consecutive synchronized-lock-high cycles required (≥1).
- RELEASE_DELAY, 16: extra cycles after the filter passes, before reset release (≥1).

Ports:
- CLK  in  1  free-running clock (not a PLL output).
- EXT_RST_N  in  1  synchronous, active-low reset.
- PLL_LOCK  in  1  PLL lock, asynchronous to CLK.
- INIT_DONE  in  1  device init complete, synchronous to CLK.
- SW_RST_REQ  in  1  single-cycle request for a full PLL recycle.
- PLL_POWERDOWN_N  out  1  to PLL POWERDOWN_N; registered.
- FABRIC_RESET_N  out  1  fabric reset, active-low; registered.
- LOCK_LOST  out  1  sticky flag: lock dropped while in RUN.
- RETRY_CNT  out  4  number of timeout retries, saturating at 15.

## Operation

- PLL_LOCK passes through a 2-flop synchronizer; the output is lock_s. All decisions use lock_s.
- One shared counter, sized $clog2 of the largest parameter.
- FSM states: PWRDN, WAIT_LOCK, FILTER, RELEASE, RUN. The counter clears on every state entry.
- PWRDN: PLL_POWERDOWN_N=0. The counter increments each cycle; at count PD_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: PLL_POWERDOWN_N=1.
  - lock_s=1: go to FILTER.
  - Counter reaches LOCK_TIMEOUT-1: go to PWRDN and increment RETRY_CNT (saturating).
- FILTER:
  - lock_s=0: return to WAIT_LOCK. The timeout restarts from 0.
  - Counter reaches LOCK_FILTER-1 with lock_s=1: go to RELEASE.
- RELEASE:
  - lock_s=0: go to WAIT_LOCK.
  - Counter saturates at RELEASE_DELAY-1. Once saturated and INIT_DONE=1, go to RUN. Otherwise hold in RELEASE.
- RUN:
  - lock_s=0: go to WAIT_LOCK and set LOCK_LOST. The PLL is not powered down.
- SW_RST_REQ in any state except PWRDN: go to PWRDN. It has priority over all other transitions. In PWRDN the request is ignored and the counter is not restarted.
- If SW_RST_REQ and a RUN lock drop occur in the same cycle: go to PWRDN and still set LOCK_LOST.
- FABRIC_RESET_N is registered as (next_state==RUN). It is 1 only while in RUN.
- LOCK_LOST and RETRY_CNT clear only on EXT_RST_N.

## Timing

Reset values (EXT_RST_N=0 at an edge): state=PWRDN, counter=0, PLL_POWERDOWN_N=0, FABRIC_RESET_N=0, LOCK_LOST=0, RETRY_CNT=0, synchronizer=0. This applies mid-operation too, effective at the next edge.

- Powerdown release: PLL_POWERDOWN_N rises at the PD_CYCLES-th edge with EXT_RST_N=1.
- Lock to reset release: take the first edge sampling PLL_LOCK=1 as edge 0, with INIT_DONE=1. FABRIC_RESET_N rises at edge 2+LOCK_FILTER+RELEASE_DELAY.
- Lock loss: PLL_LOCK sampled 0 at edge 0 gives FABRIC_RESET_N=0 at edge 2.
- Timeout: WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles; PLL_POWERDOWN_N falls on the following edge.
- SW_RST_REQ sampled at edge 0 gives PLL_POWERDOWN_N=0 and FABRIC_RESET_N=0 at edge 1.

## Test plan

Parameters for all scenarios: PD_CYCLES=4, LOCK_TIMEOUT=64, LOCK_FILTER=8, RELEASE_DELAY=4.

- Power-up: release EXT_RST_N, with PLL_LOCK rising 10 cycles after PLL_POWERDOWN_N and INIT_DONE=1.
  - PLL_POWERDOWN_N rises on the 4th edge.
  - FABRIC_RESET_N rises 14 edges after lock is sampled.
  - LOCK_LOST=0, RETRY_CNT=0.
- Glitchy lock: PLL_LOCK high 5 cycles, low 1, then high.
  - The filter restarts.
  - FABRIC_RESET_N rises 14 edges after the second rise.
- Timeout: PLL_LOCK held 0.
  - PLL_POWERDOWN_N low for 4 cycles every 68 cycles.
  - RETRY_CNT counts 1, 2, … and saturates at 15 after 15 retries.
  - FABRIC_RESET_N stays 0 throughout.
- Lock loss in RUN: drop PLL_LOCK.
  - FABRIC_RESET_N=0 two edges later; LOCK_LOST=1; PLL_POWERDOWN_N stays 1.
  - Restore lock: FABRIC_RESET_N=1 after 14 edges; LOCK_LOST remains 1.
- INIT_DONE late: INIT_DONE=0 through the filter, then set at cycle 100.
  - FABRIC_RESET_N=1 on the edge after INIT_DONE is sampled 1.
- SW_RST_REQ in the same cycle as a lock drop in RUN:
  - PWRDN entered; PLL_POWERDOWN_N=0 for 4 cycles; LOCK_LOST=1.
- EXT_RST_N asserted mid-FILTER: every output takes its reset value at the next edge.

Source files
------------

// File: rtl/pll_lock_reset_ctrl.sv
// pll_lock_reset_ctrl
//
// Sequences the fabric CCC/PLL from a free-running clock that is not derived
// from the PLL. The PLL is held in powerdown for a fixed time, then lock is
// awaited (with retry on timeout), filtered, and the fabric reset is released
// once lock is stable and device initialisation has completed.
//
// Ports:
//   CLK              free-running clock (not a PLL output)
//   EXT_RST_N        synchronous active-low reset
//   PLL_LOCK         PLL lock, asynchronous to CLK (synchronized internally)
//   INIT_DONE        device init complete, synchronous to CLK
//   SW_RST_REQ       single-cycle request for a full PLL recycle
//   PLL_POWERDOWN_N  drives the PLL POWERDOWN_N pin, registered
//   FABRIC_RESET_N   fabric reset, active-low, registered, high only in RUN
//   LOCK_LOST        sticky: lock dropped while in RUN
//   RETRY_CNT        lock-timeout retries, saturating at 15
//
// state     | meaning
// ----------+--------------------------------------------------------------
// PWRDN     | PLL held in powerdown for PD_CYCLES cycles
// WAIT_LOCK | PLL powered, waiting for lock; times out after LOCK_TIMEOUT
// FILTER    | lock seen, needs LOCK_FILTER consecutive high cycles
// RELEASE   | lock stable, waiting RELEASE_DELAY cycles and INIT_DONE
// RUN       | fabric out of reset; a lock drop returns to WAIT_LOCK

module pll_lock_reset_ctrl #(
    parameter int PD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int LOCK_FILTER   = 256,
    parameter int RELEASE_DELAY = 16
) (
    input  logic       CLK,
    input  logic       EXT_RST_N,
    input  logic       PLL_LOCK,
    input  logic       INIT_DONE,
    input  logic       SW_RST_REQ,
    output logic       PLL_POWERDOWN_N,
    output logic       FABRIC_RESET_N,
    output logic       LOCK_LOST,
    output logic [3:0] RETRY_CNT
);

    localparam int MAX_AB = (PD_CYCLES > LOCK_TIMEOUT) ? PD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_FILTER > RELEASE_DELAY) ? LOCK_FILTER : RELEASE_DELAY;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] PD_LAST   = CW'(PD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_DELAY - 1);

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          lock_meta;
    logic          lock_s;
    logic          sw_req_q;
    logic          timeout_hit;
    logic          drop_in_run;
    logic          cnt_advance;

    // Next-state decision. The software request is applied last so that it
    // overrides every other transition, but a RUN lock drop seen in the same
    // cycle is still recorded as lost lock.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        drop_in_run = 1'b0;
        case (state)
            PWRDN: begin
                if (cnt == PD_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = FILTER;
                end else if (cnt == TO_LAST) begin
                    state_nxt   = PWRDN;
                    timeout_hit = 1'b1;
                end
            end
            FILTER: begin
                if (!lock_s)                state_nxt = WAIT_LOCK;
                else if (cnt == FILT_LAST)  state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!lock_s)                              state_nxt = WAIT_LOCK;
                else if ((cnt == REL_LAST) && INIT_DONE)  state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt   = WAIT_LOCK;
                    drop_in_run = 1'b1;
                end
            end
            default: state_nxt = PWRDN;
        endcase
        if (sw_req_q && (state != PWRDN)) begin
            state_nxt   = PWRDN;
            timeout_hit = 1'b0;
        end
    end

    // RELEASE holds its count once the delay has elapsed; RUN needs no count.
    always_comb begin
        cnt_advance = 1'b0;
        case (state)
            PWRDN, WAIT_LOCK, FILTER: cnt_advance = 1'b1;
            RELEASE:                  cnt_advance = (cnt != REL_LAST);
            default:                  cnt_advance = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!EXT_RST_N) begin
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            sw_req_q        <= 1'b0;
            state           <= PWRDN;
            cnt             <= '0;
            PLL_POWERDOWN_N <= 1'b0;
            FABRIC_RESET_N  <= 1'b0;
            LOCK_LOST       <= 1'b0;
            RETRY_CNT       <= 4'd0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
            sw_req_q  <= SW_RST_REQ;
            state     <= state_nxt;

            if (state_nxt != state) cnt <= '0;
            else if (cnt_advance)   cnt <= cnt + CW'(1);

            PLL_POWERDOWN_N <= (state_nxt != PWRDN);
            FABRIC_RESET_N  <= (state_nxt == RUN);

            if (drop_in_run) LOCK_LOST <= 1'b1;
            if (timeout_hit && (RETRY_CNT != 4'hF)) RETRY_CNT <= RETRY_CNT + 4'd1;
        end
    end

endmodule
